// File: rtl/i2c_target_regs.sv
// i2c_target_regs: 7-bit-address I2C target exposing a 2**REG_AW byte register file plus a local tap.
// Latency: bus events act 3 clk after the pad edge; wr_valid 1 clk after the 8th data rise; loc_rdata 1 clk.
// Backpressure: none; the I2C master paces all traffic and the local ports never stall.
module i2c_target_regs #(
   parameter logic [6:0] DEV_ADDR = 7'h39,
   parameter int         REG_AW   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              sda_oe,
   output logic              wr_valid,
   output logic [REG_AW-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic [REG_AW-1:0] loc_raddr,
   output logic [7:0]        loc_rdata
);

   localparam int NREG = 1 << REG_AW;

   typedef enum logic [3:0] {
      S_IDLE,
      S_DEV,
      S_DACK,
      S_REGA,
      S_RACK,
      S_WDAT,
      S_WACK,
      S_RDAT,
      S_MACK,
      S_IGNORE
   } state_t;

   // [0],[1] are the two synchroniser stages, [2] is the edge-detect history.
   logic [2:0]        scl_sync_q, scl_sync_d;
   logic [2:0]        sda_sync_q, sda_sync_d;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [7:0]        sh_q, sh_d;
   logic              rw_q, rw_d;
   logic [REG_AW-1:0] ptr_q, ptr_d;
   logic              oe_q, oe_d;

   logic              wr_valid_q, wr_valid_d;
   logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic [7:0]        loc_rdata_q, loc_rdata_d;

   logic [7:0]        regs_q [NREG];

   logic              scl_rise, scl_fall, start_ev, stop_ev, sda_s;
   logic [7:0]        rx_byte;
   logic              wr_en;

   // Shift the pad inputs into their synchroniser/history chains.
   always_comb begin
      scl_sync_d = {scl_sync_q[1:0], scl_i};
      sda_sync_d = {sda_sync_q[1:0], sda_i};
   end

   // Synchroniser flops reset to 1 (idle bus) so no phantom edge appears after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
      end
   end

   // Decode bus events from the synchronised level and its one-clk history.
   always_comb begin
      sda_s    = sda_sync_q[1];
      scl_rise =  scl_sync_q[1] & ~scl_sync_q[2];
      scl_fall = ~scl_sync_q[1] &  scl_sync_q[2];
      start_ev =  scl_sync_q[1] &  scl_sync_q[2] & ~sda_sync_q[1] &  sda_sync_q[2];
      stop_ev  =  scl_sync_q[1] &  scl_sync_q[2] &  sda_sync_q[1] & ~sda_sync_q[2];
   end

   // Protocol next-state: STOP/START override everything, else per-state bit handling.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      rw_d    = rw_q;
      ptr_d   = ptr_q;
      oe_d    = oe_q;
      wr_en   = 1'b0;
      rx_byte = {sh_q[6:0], sda_s};

      if (stop_ev) begin
         state_d = S_IDLE;
         oe_d    = 1'b0;
         cnt_d   = 4'd0;
      end else if (start_ev) begin
         state_d = S_DEV;
         oe_d    = 1'b0;
         cnt_d   = 4'd0;
      end else begin
         case (state_q)
            S_DEV, S_REGA, S_WDAT: begin
               if (scl_rise) begin
                  sh_d  = rx_byte;
                  cnt_d = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d = 4'd0;
                     case (state_q)
                        S_DEV: begin
                           if (rx_byte[7:1] == DEV_ADDR) begin
                              rw_d    = rx_byte[0];
                              state_d = S_DACK;
                           end else begin
                              state_d = S_IGNORE;
                           end
                        end
                        S_REGA: begin
                           ptr_d   = rx_byte[REG_AW-1:0];
                           state_d = S_RACK;
                        end
                        default: begin
                           wr_en   = 1'b1;
                           ptr_d   = ptr_q + REG_AW'(1);
                           state_d = S_WACK;
                        end
                     endcase
                  end
               end
            end

            // First SCL fall after bit 8 pulls SDA low, the next one releases it.
            S_DACK, S_RACK, S_WACK: begin
               if (scl_fall) begin
                  if (!oe_q) begin
                     oe_d = 1'b1;
                  end else begin
                     oe_d = 1'b0;
                     if (state_q == S_DACK && rw_q) begin
                        // Read: the ACK-ending fall already presents data bit 7.
                        sh_d    = regs_q[ptr_q];
                        oe_d    = ~regs_q[ptr_q][7];
                        state_d = S_RDAT;
                     end else if (state_q == S_DACK) begin
                        state_d = S_REGA;
                     end else begin
                        state_d = S_WDAT;
                     end
                  end
               end
            end

            // cnt counts master SCL rises; each following fall presents the next bit.
            S_RDAT: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     oe_d    = 1'b0;
                     cnt_d   = 4'd0;
                     ptr_d   = ptr_q + REG_AW'(1);
                     state_d = S_MACK;
                  end else begin
                     oe_d = ~sh_q[3'd7 - cnt_q[2:0]];
                  end
               end
            end

            // cnt=1 records a master ACK; the following fall starts the next byte.
            S_MACK: begin
               if (scl_rise) begin
                  if (sda_s) begin
                     state_d = S_IGNORE;
                  end else begin
                     cnt_d = 4'd1;
                  end
               end else if (scl_fall && cnt_q == 4'd1) begin
                  cnt_d   = 4'd0;
                  sh_d    = regs_q[ptr_q];
                  oe_d    = ~regs_q[ptr_q][7];
                  state_d = S_RDAT;
               end
            end

            S_IGNORE: oe_d = 1'b0;

            default: oe_d = 1'b0;
         endcase
      end
   end

   // Local write-notify and registered read port; same-clk collisions return the old byte.
   always_comb begin
      wr_valid_d  = wr_en;
      wr_addr_d   = wr_en ? ptr_q : wr_addr_q;
      wr_data_d   = wr_en ? rx_byte : wr_data_q;
      loc_rdata_d = regs_q[loc_raddr];
   end

   // Protocol and output state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         sh_q        <= 8'h00;
         rw_q        <= 1'b0;
         ptr_q       <= '0;
         oe_q        <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 8'h00;
         loc_rdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         rw_q        <= rw_d;
         ptr_q       <= ptr_d;
         oe_q        <= oe_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         loc_rdata_q <= loc_rdata_d;
      end
   end

   // Register file: written on the 8th SCL rise of a data byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= 8'h00;
         end
      end else if (wr_en) begin
         regs_q[ptr_q] <= rx_byte;
      end
   end

   assign sda_oe    = oe_q;
   assign wr_valid  = wr_valid_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign loc_rdata = loc_rdata_q;

endmodule
